// File: rtl/bet_conduit_tx.sv
// bet_conduit_tx
// Transmit end of the 6-bit bet conduit. Accepts 5-bit bet values from a
// valid/ready source into a small FIFO. Each value is sent as one frame:
// the payload is driven on datac[4:0], and after SETUP_CYCLES cycles the
// datac[5] strobe toggles. The payload is then held for HOLD_CYCLES cycles.
//
// Ports
//   clk_clk      in   system clock, rising edge
//   reset_reset  in   synchronous active-high reset
//   in_data      in   5-bit bet value
//   in_valid     in   in_data valid
//   in_ready     out  buffer can accept (combinational, low during reset)
//   datac        out  conduit: [5]=toggle strobe, [4:0]=payload
//   busy         out  frame in progress or buffer non-empty
//   fifo_level   out  entries currently buffered
//   frames_sent  out  completed frame count, wraps
module bet_conduit_tx #(
    parameter int SETUP_CYCLES = 4,
    parameter int HOLD_CYCLES  = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [4:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [5:0]                    datac,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frames_sent
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, HOLD} state_t;

    state_t          state, state_next;
    logic [4:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic [CW-1:0]   cnt, cnt_next;
    logic [5:0]      datac_next;
    logic [15:0]     frame_cnt;
    logic            frame_done;
    logic            push, pop, full;

    assign full        = (level == LW'(FIFO_DEPTH));
    assign in_ready    = !reset_reset && !full;
    assign push        = in_valid && in_ready;
    assign fifo_level  = level;
    assign frames_sent = frame_cnt;
    assign busy        = (state != IDLE) || (level != '0);

    // Pop decision uses the registered level, so a push into an empty
    // buffer becomes visible to the FSM one cycle later.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        datac_next = datac;
        frame_done = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0) begin
                    pop             = 1'b1;
                    datac_next[4:0] = mem[rd_ptr];
                    cnt_next        = '0;
                    state_next      = SETUP;
                end
            end
            SETUP: begin
                if (cnt == CW'(SETUP_CYCLES - 1)) begin
                    datac_next[5] = ~datac[5];
                    cnt_next      = '0;
                    state_next    = HOLD;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            datac     <= '0;
            cnt       <= '0;
            frame_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            datac <= datac_next;
            cnt   <= cnt_next;
            if (frame_done) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_bet_conduit_tx.sv
module tb_bet_conduit_tx;

    localparam int SETUP = 4;
    localparam int HOLD  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  datac;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [15:0] frames_sent;

    int checks   = 0;
    int failures = 0;

    bet_conduit_tx #(
        .SETUP_CYCLES(SETUP),
        .HOLD_CYCLES (HOLD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_clk    (clk),
        .reset_reset(rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .datac      (datac),
        .busy       (busy),
        .fifo_level (fifo_level),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of accepted values and the age of the
    // frame on the wire. Toggle at age SETUP, frame ends at SETUP+HOLD.
    logic [4:0]  mq[$];
    bit          m_valid  = 0;
    bit          m_active = 0;
    int          m_age    = 0;
    logic        m_strobe = 0;
    logic [4:0]  m_payload = '0;
    logic [15:0] m_frames = '0;
    int          m_pre;
    bit          m_push;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_active  = 0;
            m_age     = 0;
            m_strobe  = 0;
            m_payload = '0;
            m_frames  = '0;
            m_valid   = 1;
        end else if (m_valid) begin
            m_pre  = mq.size();
            m_push = in_valid && (m_pre < DEPTH);
            if (m_active) begin
                m_age++;
                if (m_age == SETUP) m_strobe = ~m_strobe;
                if (m_age == SETUP + HOLD) begin
                    m_frames++;
                    m_active = 0;
                end
            end else if (m_pre != 0) begin
                m_payload = mq.pop_front();
                m_active  = 1;
                m_age     = 0;
            end
            if (m_push) mq.push_back(in_data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("datac", datac, {m_strobe, m_payload});
            chk("fifo_level", fifo_level, mq.size());
            chk("busy", busy, (m_active || mq.size() != 0));
            chk("frames_sent", frames_sent, m_frames);
            chk("in_ready", in_ready, (!rst && mq.size() < DEPTH));
        end
    end

    // Strobe edge capture: datac value and cycle number at every toggle.
    bit         cap_en = 0;
    logic       prev5 = 1'b0;
    int         cyc = 0;
    logic [5:0] tq[$];
    int         tt[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (cap_en && datac[5] !== prev5) begin
            tq.push_back(datac);
            tt.push_back(cyc);
        end
        prev5 = datac[5];
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_seq(input logic [4:0] v[$], output bit saw_full);
        int idx = 0;
        int guard = 0;
        bit acc;
        saw_full = 0;
        while (idx < v.size() && guard < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = v[idx];
            #1;
            acc = in_ready;
            if (!acc && fifo_level == 3'd4) saw_full = 1;
            @(posedge clk);
            if (acc) idx++;
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("push_seq_all_accepted", idx, v.size());
    endtask

    task automatic wait_frames(input logic [15:0] target, input int budget);
        int n = 0;
        while (frames_sent !== target && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("wait_frames", frames_sent, target);
    endtask

    task automatic send_and_check(input logic [4:0] v, input logic [5:0] pre,
                                  input logic [5:0] post, input logic [15:0] fr);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        #1;
        chk("single_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("single_payload_A1", datac, pre);
        repeat (4) @(posedge clk);
        #2;
        chk("single_toggle_A5", datac, post);
        repeat (4) @(posedge clk);
        #2;
        chk("single_busy_A9", busy, 0);
        chk("single_frames_A9", frames_sent, fr);
        chk("single_level_A9", fifo_level, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] vals[$];
        bit sf;

        // Test 1: reset then idle
        do_reset();
        repeat (20) @(posedge clk);
        #2;
        chk("t1_datac", datac, 6'h00);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_busy", busy, 0);
        chk("t1_frames", frames_sent, 0);

        // Test 2: single value with default timing
        send_and_check(5'h15, 6'h15, 6'h35, 16'd1);

        // Test 3: six values back-to-back after reset
        do_reset();
        tq.delete();
        tt.delete();
        cap_en = 1;
        vals = '{5'h01, 5'h02, 5'h03, 5'h1A, 5'h1F, 5'h0C};
        push_seq(vals, sf);
        chk("t3_saw_full", sf, 1);
        wait_frames(16'd6, 120);
        repeat (2) @(posedge clk);
        #2;
        chk("t3_toggle_count", tq.size(), 6);
        if (tq.size() == 6) begin
            chk("t3_frame0", tq[0], 6'h21);
            chk("t3_frame1", tq[1], 6'h02);
            chk("t3_frame2", tq[2], 6'h23);
            chk("t3_frame3", tq[3], 6'h1A);
            chk("t3_frame4", tq[4], 6'h3F);
            chk("t3_frame5", tq[5], 6'h0C);
            for (int i = 1; i < 6; i++) chk("t3_spacing", tt[i] - tt[i-1], 9);
        end

        // Test 4: identical values still produce one frame each
        tq.delete();
        tt.delete();
        vals = '{5'h07, 5'h07};
        push_seq(vals, sf);
        wait_frames(16'd8, 60);
        repeat (2) @(posedge clk);
        #2;
        chk("t4_toggle_count", tq.size(), 2);
        if (tq.size() == 2) begin
            chk("t4_frame0", tq[0], 6'h27);
            chk("t4_frame1", tq[1], 6'h07);
        end

        // Test 5: reset during SETUP with three queued
        tq.delete();
        tt.delete();
        vals = '{5'h11, 5'h12, 5'h13, 5'h14};
        push_seq(vals, sf);
        chk("t5_level_before", fifo_level, 3);
        chk("t5_datac_before", datac, 6'h11);
        chk("t5_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("t5_datac_reset", datac, 6'h00);
        chk("t5_level_reset", fifo_level, 0);
        chk("t5_busy_reset", busy, 0);
        chk("t5_in_ready_reset", in_ready, 0);
        chk("t5_frames_reset", frames_sent, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        chk("t5_no_toggle", tq.size(), 0);
        chk("t5_still_idle", datac, 6'h00);
        send_and_check(5'h15, 6'h15, 6'h35, 16'd1);

        // Test 6: frames_sent wrap from 0xFFFF
        @(negedge clk);
        force dut.frame_cnt = 16'hFFFF;
        m_frames = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(posedge clk);
        #2;
        chk("t6_preload", frames_sent, 16'hFFFF);
        send_and_check(5'h0A, 6'h2A, 6'h0A, 16'd0);

        cap_en = 0;
        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
